// File: rtl/scoreboard.sv
// Four-digit BCD game score: counts point_add rising edges, freezes after bird_die.
// Latency: score updates at the same clk edge that samples the point_add rising edge.
// Backpressure: none; saturates at 9999 and ignores increments once dead.
module scoreboard (
  input  logic       clk,
  input  logic       rst,
  input  logic       point_add,
  input  logic       bird_die,
  output logic [3:0] points_3,
  output logic [3:0] points_2,
  output logic [3:0] points_1,
  output logic [3:0] points_0
);

  // point_add history for edge detection, and sticky game-over flag
  logic prev;
  logic dead;

  // combinational next-state of the score digits
  logic [3:0] nxt_3;
  logic [3:0] nxt_2;
  logic [3:0] nxt_1;
  logic [3:0] nxt_0;

  logic rise;
  logic at_max;
  logic inc;

  // A point counts only on a fresh 0->1 edge, while alive, not on the
  // game-over edge itself, and never past 9999.
  assign rise   = point_add & ~prev;
  assign at_max = (points_3 == 4'd9) && (points_2 == 4'd9) &&
                  (points_1 == 4'd9) && (points_0 == 4'd9);
  assign inc    = rise & ~dead & ~bird_die & ~at_max;

  // Decimal ripple increment: each digit wraps 9->0 only when all lower digits wrap.
  always_comb begin
    nxt_3 = points_3;
    nxt_2 = points_2;
    nxt_1 = points_1;
    nxt_0 = points_0;
    if (inc) begin
      if (points_0 != 4'd9) begin
        nxt_0 = points_0 + 4'd1;
      end else begin
        nxt_0 = 4'd0;
        if (points_1 != 4'd9) begin
          nxt_1 = points_1 + 4'd1;
        end else begin
          nxt_1 = 4'd0;
          if (points_2 != 4'd9) begin
            nxt_2 = points_2 + 4'd1;
          end else begin
            nxt_2 = 4'd0;
            // at_max excludes the 9999 case, so points_3 is below 9 here
            nxt_3 = points_3 + 4'd1;
          end
        end
      end
    end
  end

  // Edge history and dead flag; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev <= 1'b0;
      dead <= 1'b0;
    end else begin
      prev <= point_add;
      if (bird_die) begin
        dead <= 1'b1;
      end
    end
  end

  // Score digit registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      points_3 <= 4'd0;
      points_2 <= 4'd0;
      points_1 <= 4'd0;
      points_0 <= 4'd0;
    end else begin
      points_3 <= nxt_3;
      points_2 <= nxt_2;
      points_1 <= nxt_1;
      points_0 <= nxt_0;
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for scoreboard: reset behaviour, edge counting, BCD carry,
// saturation at 9999 and game-over freeze.
module tb_scoreboard;

  logic       clk;
  logic       rst;
  logic       point_add;
  logic       bird_die;
  logic [3:0] points_3;
  logic [3:0] points_2;
  logic [3:0] points_1;
  logic [3:0] points_0;

  int checks;
  int errors;

  scoreboard dut (
    .clk       (clk),
    .rst       (rst),
    .point_add (point_add),
    .bird_die  (bird_die),
    .points_3  (points_3),
    .points_2  (points_2),
    .points_1  (points_1),
    .points_0  (points_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Integer score to the expected packed BCD digits {thousands..ones}.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'(v / 1000);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] exp);
    logic [15:0] obs;
    obs = {points_3, points_2, points_1, points_0};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One point_add rising edge taking two clocks.
  task automatic pulse();
    point_add = 1'b1;
    tick();
    point_add = 1'b0;
    tick();
  endtask

  // n pulses from a known starting score, checking the score after each one.
  task automatic run_pulses(input int n, input int start, input string tag);
    for (int i = 1; i <= n; i++) begin
      pulse();
      check(tag, to_bcd(start + i));
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    point_add = 1'b0;
    bird_die  = 1'b0;

    // Reset held: point_add toggling every edge must not move the score.
    for (int i = 0; i < 20; i++) begin
      point_add = i[0] ? 1'b0 : 1'b1;
      tick();
      check("reset_hold", 16'h0000);
    end

    // Release reset, one rising edge every two clocks for 24 edges.
    point_add = 1'b0;
    rst = 1'b1;
    tick();
    check("after_release", 16'h0000);
    for (int i = 0; i < 24; i++) begin
      point_add = i[0] ? 1'b0 : 1'b1;
      tick();
    end
    check("toggle_24", 16'h0012);

    // Held high for 10 cycles counts once, visible at the first edge.
    point_add = 1'b1;
    tick();
    check("hold_first_edge", 16'h0013);
    for (int i = 0; i < 9; i++) tick();
    point_add = 1'b0;
    tick();
    check("hold_10", 16'h0013);

    // Climb to 0090, then 9 more -> 0099, one more carries twice -> 0100.
    for (int i = 0; i < 77; i++) pulse();
    check("at_0090", 16'h0090);
    run_pulses(9, 90, "to_0099");
    pulse();
    check("carry_0100", 16'h0100);

    // Full range from zero: every step compared, crossing 0999->1000 etc.
    rst = 1'b0;
    tick();
    check("reset_midgame", 16'h0000);
    rst = 1'b1;
    run_pulses(9999, 0, "count_up");
    pulse();
    check("saturate_9999", 16'h9999);
    point_add = 1'b1;
    tick();
    check("saturate_again", 16'h9999);
    point_add = 1'b0;
    tick();

    // Game over coinciding with a rising edge suppresses it; dead is sticky.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) pulse();
    check("at_0005", 16'h0005);
    point_add = 1'b1;
    bird_die  = 1'b1;
    tick();
    check("die_with_edge", 16'h0005);
    bird_die  = 1'b0;
    point_add = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      pulse();
      check("dead_ignores", 16'h0005);
    end

    // One-edge reset while dead restarts the game.
    rst = 1'b0;
    tick();
    check("reset_dead", 16'h0000);
    rst = 1'b1;
    point_add = 1'b1;
    tick();
    check("alive_after_reset", 16'h0001);
    point_add = 1'b0;
    tick();

    // point_add already high through reset counts at the first edge after it.
    rst = 1'b0;
    point_add = 1'b1;
    tick();
    check("reset_pa_high", 16'h0000);
    rst = 1'b1;
    tick();
    check("first_edge_counts", 16'h0001);
    point_add = 1'b0;
    tick();

    // bird_die during reset is overridden: dead stays clear.
    rst = 1'b0;
    bird_die = 1'b1;
    tick();
    rst = 1'b1;
    bird_die = 1'b0;
    pulse();
    check("die_in_reset_ignored", 16'h0001);
    pulse();
    check("still_counting", 16'h0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/scoreboard.md
SCOREBOARD -- requirements
Module: scoreboard

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-low; rst=0 sampled at a clk rising edge resets the block.
REQ-004 point_add  input  1  score-increment request; only a 0->1 transition counts.
REQ-005 bird_die  input  1  game-over indication; freezes the score.
REQ-006 points_3  output  4  BCD thousands digit, registered.
REQ-007 points_2  output  4  BCD hundreds digit, registered.
REQ-008 points_1  output  4  BCD tens digit, registered.
REQ-009 points_0  output  4  BCD ones digit, registered.

Function
REQ-010 Internal state SHALL be exactly: four BCD digit registers, a 1-bit point_add history register (prev) and a 1-bit sticky dead flag.
REQ-011 At every clk rising edge with rst=1, prev SHALL load the sampled point_add.
REQ-012 A rising edge SHALL be detected at a clk edge where the sampled point_add=1 and prev=0.
REQ-013 On a detected rising edge with dead=0 and bird_die=0, the 4-digit BCD score SHALL increment by exactly 1 at that same clk edge (zero extra latency beyond the register).
REQ-014 point_add held high for N cycles SHALL produce exactly one increment.
REQ-015 Increment SHALL be decimal with carry: points_0 9->0 carries into points_1; 9->0 in points_1 carries into points_2; 9->0 in points_2 carries into points_3.
REQ-016 Each digit SHALL only ever hold values 0-9; codes 10-15 SHALL never appear.
REQ-017 At score 9999 a further increment SHALL be ignored (saturate at 9999, no wrap to 0000).
REQ-018 bird_die=1 sampled at a clk edge SHALL set dead=1 at that edge; dead SHALL stay 1 until reset.
REQ-019 When bird_die=1 and a point_add rising edge coincide at the same clk edge, the increment SHALL be suppressed.
REQ-020 While dead=1, rising edges of point_add SHALL be ignored and all four digits SHALL hold their value.
REQ-021 prev SHALL keep tracking point_add while dead=1.

Reset
REQ-022 rst=0 at a clk edge SHALL set points_3..points_0 to 0, prev to 0 and dead to 0, overriding point_add and bird_die at that edge.
REQ-023 While rst=0 is held, the outputs SHALL stay 0000 regardless of other inputs.
REQ-024 Reset asserted mid-game or while dead=1 SHALL fully restart the block.
REQ-025 point_add=1 at the first edge after rst returns to 1 SHALL count as a rising edge, because prev=0.
REQ-026 Outputs SHALL be undefined only before the first reset edge; no asynchronous reset behaviour SHALL exist.

Verification
REQ-027 Hold rst=0 and toggle point_add every clk edge for 20 cycles -> outputs remain 0,0,0,0.
REQ-028 Release rst, then toggle point_add at every clk rising edge (one rising edge per 2 clocks) for 24 edges -> 12 increments, score 0012 (points_1=1, points_0=2).
REQ-029 Hold point_add=1 for 10 cycles, then 0 -> score rises by exactly 1.
REQ-030 Apply 9 rising edges from 0090 -> 0099; one more -> 0100. Preload to 9999 via 9999 edges, then one more -> stays 9999.
REQ-031 At score 0005, assert bird_die together with a point_add rising edge, then pulse point_add 3 more times -> score stays 0005.
REQ-032 With dead=1 at 0005, pulse rst=0 for one edge -> 0000 and dead cleared; then one point_add rising edge -> 0001.
